// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port word memory shared by instruction fetch and load/store
module mem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter bit DATA_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wmask,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_ren,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state, state_nx;
  logic              gnt_d_q;
  logic              oor_q;
  logic              wr_q;
  logic              last_d;
  logic [3:0]        wmask_q;
  logic              ren_q;
  logic              contend;
  logic              pick_d;
  logic [31:0]       sel_addr;
  logic [3:0]        sel_mask;
  logic              sel_oor;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

  // Contention goes to D when forced, otherwise to whoever lost last time.
  always_comb begin
    contend  = i_req & d_req;
    pick_d   = d_req & (~i_req | DATA_PRIO | ~last_d);
    sel_addr = pick_d ? d_addr : i_addr;
    sel_mask = pick_d ? d_wmask : 4'h0;
    sel_oor  = |sel_addr[31:ADDR_W+2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wmask_q   <= '0;
      ren_q     <= 1'b0;
      gnt_d_q   <= 1'b0;
      oor_q     <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state   <= state_nx;
      wmask_q <= '0;
      ren_q   <= 1'b0;
      if (state == IDLE && (i_req || d_req)) begin
        mem_addr  <= sel_addr[ADDR_W+1:2];
        mem_wdata <= pick_d ? d_wdata : 32'h0;
        gnt_d_q   <= pick_d;
        oor_q     <= sel_oor;
        wr_q      <= |sel_mask;
        wmask_q   <= sel_oor ? 4'h0 : sel_mask;
        ren_q     <= ~sel_oor & ~(|sel_mask);
        if (contend) last_d <= pick_d;
      end
    end
  end

  // Reset in ISSUE must suppress the strobes already presented to the memory.
  assign mem_wmask = wmask_q & {4{~reset}};
  assign mem_ren   = ren_q & ~reset;

  always_comb begin
    state_nx = state;
    i_ack    = 1'b0;
    d_ack    = 1'b0;
    i_rdata  = 32'h0;
    d_rdata  = 32'h0;
    d_err    = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:  if (i_req || d_req) state_nx = ISSUE;
      ISSUE: state_nx = RESP;
      RESP: begin
        state_nx = IDLE;
        if (gnt_d_q) begin
          d_ack   = 1'b1;
          d_err   = oor_q;
          d_rdata = (!oor_q && !wr_q) ? mem_rdata : 32'h0;
        end else begin
          i_ack   = 1'b1;
          i_rdata = !oor_q ? mem_rdata : 32'h0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
